// File: rtl/pag_pt_refill_if.sv
// Memory-read and PT-write buses of the KI10 page-table refill sequencer.
// Defining PT_PARITY_EN widens PT data to 19 bits and the directory tag to 8 bits.
interface pag_pt_refill_if #(
    parameter int PA_W = 22
);
`ifdef PT_PARITY_EN
    localparam int PT_DW = 19;
    localparam int TAG_W = 8;
`else
    localparam int PT_DW = 18;
    localparam int TAG_W = 7;
`endif

    logic             mem_rd_req_h;
    logic [PA_W-1:0]  mem_adr_h;
    logic             mem_rd_ack_h;
    logic [35:0]      mem_data_h;
    logic             mem_par_err_h;

    logic             pt_wr_h;
    logic             pt_dir_wr_h;
    logic [8:0]       pt_wr_adr_h;
    logic [PT_DW-1:0] pt_wr_data_h;
    logic [TAG_W-1:0] pt_dir_tag_h;

    // The refill sequencer is the master of both buses.
    modport master (
        output mem_rd_req_h, mem_adr_h,
        input  mem_rd_ack_h, mem_data_h, mem_par_err_h,
        output pt_wr_h, pt_dir_wr_h, pt_wr_adr_h, pt_wr_data_h, pt_dir_tag_h
    );

    modport slave (
        input  mem_rd_req_h, mem_adr_h,
        output mem_rd_ack_h, mem_data_h, mem_par_err_h,
        input  pt_wr_h, pt_dir_wr_h, pt_wr_adr_h, pt_wr_data_h, pt_dir_tag_h
    );
endinterface

// File: rtl/pag_pt_refill.sv
// KI10-mode page-table refill sequencer: fetches the page-map halfword on a PT miss and
// writes the PT entry and directory tag. Optional PT_PARITY_EN adds odd parity bits.
module pag_pt_refill #(
    parameter int PA_W    = 22,
    parameter int TIMEOUT = 255,
    parameter int RETRIES = 1
) (
    input  logic                   clk,
    input  logic                   crobar_l,
    input  logic                   refill_req_h,
    input  logic                   abort_h,
    input  logic                   vma_user_h,
    input  logic [4:0]             vma_13to17_h,
    input  logic [8:0]             vma_18to26_h,
    input  logic [12:0]            ubr_h,
    input  logic [12:0]            ebr_h,
    pag_pt_refill_if.master        bus,
    output logic                   busy_h,
    output logic                   refill_done_h,
    output logic                   page_fail_h,
    output logic [4:0]             pf_code_h
);
`ifdef PT_PARITY_EN
    localparam int PT_DW = 19;
    localparam int TAG_W = 8;
`else
    localparam int PT_DW = 18;
    localparam int TAG_W = 7;
`endif
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RT_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(RETRIES);

    localparam logic [4:0] PF_NO_ACCESS = 5'o21;
    localparam logic [4:0] PF_PARITY    = 5'o25;
    localparam logic [4:0] PF_TIMEOUT   = 5'o27;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_CHECK, S_WR_PT, S_WR_DIR, S_FAIL
    } state_e;

    state_e          r_state;
    logic [8:0]      r_vpn;
    logic            r_user;
    logic [4:0]      r_vma_hi;
    logic [17:0]     r_half;
    logic [TO_W-1:0] r_to_cnt;
    logic [RT_W-1:0] r_rt_cnt;

    logic [12:0]      w_base;
    logic [21:0]      w_map_adr;
    logic [17:0]      w_half;
    logic [6:0]       w_tag_raw;
    logic [PT_DW-1:0] w_pt_data;
    logic [TAG_W-1:0] w_dir_tag;

    // Map word address: two halfword entries per word, so the vpn is halved.
    assign w_base    = r_user ? ubr_h : ebr_h;
    assign w_map_adr = {w_base, 9'd0} + {14'd0, r_vpn[8:1]};
    assign w_half    = r_vpn[0] ? bus.mem_data_h[17:0] : bus.mem_data_h[35:18];
    assign w_tag_raw = {1'b1, r_user, r_vma_hi};

`ifdef PT_PARITY_EN
    assign w_pt_data = {~^r_half, r_half};
    assign w_dir_tag = {~^w_tag_raw, w_tag_raw};
`else
    assign w_pt_data = r_half;
    assign w_dir_tag = w_tag_raw;
`endif

    // NOTE: state and registered outputs use <= so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge crobar_l) begin
        if (!crobar_l) begin
            r_state          <= S_IDLE;
            r_vpn            <= '0;
            r_user           <= 1'b0;
            r_vma_hi         <= '0;
            r_half           <= '0;
            r_to_cnt         <= '0;
            r_rt_cnt         <= '0;
            bus.mem_rd_req_h <= 1'b0;
            bus.mem_adr_h    <= '0;
            bus.pt_wr_h      <= 1'b0;
            bus.pt_dir_wr_h  <= 1'b0;
            bus.pt_wr_adr_h  <= '0;
            bus.pt_wr_data_h <= '0;
            bus.pt_dir_tag_h <= '0;
            busy_h           <= 1'b0;
            refill_done_h    <= 1'b0;
            page_fail_h      <= 1'b0;
            pf_code_h        <= '0;
        end else begin
            bus.pt_wr_h     <= 1'b0;
            bus.pt_dir_wr_h <= 1'b0;
            refill_done_h   <= 1'b0;
            page_fail_h     <= 1'b0;

            if (r_state != S_IDLE && abort_h) begin
                // Abort outranks a same-cycle ack; nothing further is written or signalled.
                r_state          <= S_IDLE;
                busy_h           <= 1'b0;
                bus.mem_rd_req_h <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (refill_req_h) begin
                            r_vpn    <= vma_18to26_h;
                            r_user   <= vma_user_h;
                            r_vma_hi <= vma_13to17_h;
                            r_to_cnt <= '0;
                            r_rt_cnt <= '0;
                            pf_code_h <= '0;
                            busy_h   <= 1'b1;
                            r_state  <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        bus.mem_adr_h    <= PA_W'(w_map_adr);
                        bus.mem_rd_req_h <= 1'b1;
                        r_to_cnt         <= '0;
                        r_state          <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (bus.mem_rd_ack_h) begin
                            bus.mem_rd_req_h <= 1'b0;
                            if (bus.mem_par_err_h) begin
                                if (r_rt_cnt < RT_MAX) begin
                                    r_rt_cnt <= r_rt_cnt + 1'b1;
                                    r_state  <= S_REQ;
                                end else begin
                                    page_fail_h <= 1'b1;
                                    pf_code_h   <= PF_PARITY;
                                    r_state     <= S_FAIL;
                                end
                            end else begin
                                r_half  <= w_half;
                                r_state <= S_CHECK;
                            end
                        end else if (r_to_cnt == TO_LAST) begin
                            bus.mem_rd_req_h <= 1'b0;
                            page_fail_h      <= 1'b1;
                            pf_code_h        <= PF_TIMEOUT;
                            r_state          <= S_FAIL;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (!r_half[17]) begin
                            page_fail_h <= 1'b1;
                            pf_code_h   <= PF_NO_ACCESS;
                            r_state     <= S_FAIL;
                        end else begin
                            bus.pt_wr_h      <= 1'b1;
                            bus.pt_wr_adr_h  <= r_vpn;
                            bus.pt_wr_data_h <= w_pt_data;
                            r_state          <= S_WR_PT;
                        end
                    end
                    S_WR_PT: begin
                        bus.pt_dir_wr_h  <= 1'b1;
                        bus.pt_dir_tag_h <= w_dir_tag;
                        refill_done_h    <= 1'b1;
                        r_state          <= S_WR_DIR;
                    end
                    S_WR_DIR, S_FAIL: begin
                        busy_h  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        busy_h  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pag_pt_refill.sv
// Randomized bench for pag_pt_refill: a per-transaction timeline model predicts every output cycle.
// Build with PT_PARITY_EN defined to exercise the parity-widened PT data and tag.
`timescale 1ns/1ps
module tb_pag_pt_refill;
    localparam int PA_W    = 22;
    localparam int TIMEOUT = 255;
    localparam int RETRIES = 1;
`ifdef PT_PARITY_EN
    localparam int PT_DW = 19;
    localparam int TAG_W = 8;
`else
    localparam int PT_DW = 18;
    localparam int TAG_W = 7;
`endif

    typedef struct packed {
        logic             busy, rd_req, pt_wr, dir_wr, done, fail;
        logic [4:0]       code;
        logic [PA_W-1:0]  adr;
        logic [8:0]       pt_adr;
        logic [PT_DW-1:0] pt_data;
        logic [TAG_W-1:0] tag;
    } obs_t;

    typedef struct packed {
        logic        req, abort, ack, perr, scr;
        logic [35:0] data;
    } stim_t;

    logic        clk = 1'b0;
    logic        crobar_l = 1'b0;
    logic        refill_req_h = 1'b0, abort_h = 1'b0, vma_user_h = 1'b0;
    logic [4:0]  vma_13to17_h = '0;
    logic [8:0]  vma_18to26_h = '0;
    logic [12:0] ubr_h = '0, ebr_h = '0;
    logic        busy_h, refill_done_h, page_fail_h;
    logic [4:0]  pf_code_h;

    pag_pt_refill_if #(.PA_W(PA_W)) bus();

    pag_pt_refill #(.PA_W(PA_W), .TIMEOUT(TIMEOUT), .RETRIES(RETRIES)) dut (
        .clk(clk), .crobar_l(crobar_l), .refill_req_h(refill_req_h), .abort_h(abort_h),
        .vma_user_h(vma_user_h), .vma_13to17_h(vma_13to17_h), .vma_18to26_h(vma_18to26_h),
        .ubr_h(ubr_h), .ebr_h(ebr_h), .bus(bus), .busy_h(busy_h),
        .refill_done_h(refill_done_h), .page_fail_h(page_fail_h), .pf_code_h(pf_code_h)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0;
    obs_t exp_cur = '0;
    bit exp_vld = 1'b0;
    logic [4:0] pf_model = '0;
    stim_t sq[$];
    obs_t  eq[$];
    bit          t_user;
    logic [8:0]  t_vpn;
    logic [4:0]  t_vma;
    logic [12:0] t_ubr, t_ebr;

    // Monitor tallies used by the literal expectations.
    int req_hi = 0, req_rise = 0, pulses = 0, pt_wr_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic prev_req = 1'b0;
    logic [PA_W-1:0]  last_adr = '0;
    logic [PT_DW-1:0] last_pt = '0;
    logic [TAG_W-1:0] last_tag = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_rd_req_h) begin
            req_hi   <= req_hi + 1;
            last_adr <= bus.mem_adr_h;
            if (!prev_req) req_rise <= req_rise + 1;
        end
        prev_req <= bus.mem_rd_req_h;
        if (bus.pt_wr_h) begin
            pt_wr_cnt <= pt_wr_cnt + 1;
            last_pt   <= bus.pt_wr_data_h;
        end
        if (bus.pt_dir_wr_h) last_tag <= bus.pt_dir_tag_h;
        if (refill_done_h) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (bus.pt_wr_h || bus.pt_dir_wr_h || refill_done_h || page_fail_h) pulses <= pulses + 1;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({busy_h, refill_done_h, page_fail_h, pf_code_h, bus.mem_rd_req_h, bus.mem_adr_h,
                     bus.pt_wr_h, bus.pt_dir_wr_h, bus.pt_wr_adr_h, bus.pt_wr_data_h, bus.pt_dir_tag_h});
    endfunction

    // The single compare process: every modelled cycle, fields masked where not meaningful.
    always @(negedge clk) begin
        if (exp_vld) begin
            obs_t a;
            a.busy = busy_h; a.rd_req = bus.mem_rd_req_h; a.pt_wr = bus.pt_wr_h;
            a.dir_wr = bus.pt_dir_wr_h; a.done = refill_done_h; a.fail = page_fail_h;
            a.code = pf_code_h; a.adr = bus.mem_adr_h; a.pt_adr = bus.pt_wr_adr_h;
            a.pt_data = bus.pt_wr_data_h; a.tag = bus.pt_dir_tag_h;
            if (!exp_cur.rd_req) a.adr = '0;
            if (!exp_cur.pt_wr) begin a.pt_adr = '0; a.pt_data = '0; end
            if (!exp_cur.dir_wr) a.tag = '0;
            check($sformatf("cyc%0d", cyc), 128'(a), 128'(exp_cur));
        end
    end

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [35:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    function automatic obs_t o_idle();
        obs_t o = '0;
        o.code = pf_model;
        return o;
    endfunction

    task automatic push(input logic req, input logic ab, input logic ack, input logic perr,
                        input logic scr, input logic [35:0] data, input obs_t o);
        stim_t s;
        s.req = req; s.abort = ab; s.ack = ack; s.perr = perr; s.scr = scr; s.data = data;
        sq.push_back(s);
        eq.push_back(o);
    endtask

    task automatic push_fail(input logic [4:0] code);
        obs_t w = '0;
        w.busy = 1'b1; w.fail = 1'b1; w.code = code;
        push(rb(), 1'b0, 1'b0, 1'b0, 1'b1, rnd36(), w);
        pf_model = code;
    endtask

    // Model: the whole transaction timeline, cycle 0 being the cycle the request is sampled.
    task automatic build(input bit user, input logic [8:0] vpn, input logic [4:0] vma,
                         input logic [12:0] ubr, input logic [12:0] ebr, input logic [17:0] hw,
                         input int d0, input int d1, input bit p0, input bit p1,
                         input int abort_at, input int gap);
        obs_t ob, w;
        logic [35:0] word;
        logic [PA_W-1:0] exp_adr;
        logic [PT_DW-1:0] exp_pt;
        logic [TAG_W-1:0] exp_tag;
        logic [6:0] tag7;
        int att, d, nw;
        bit p, fin, aborted;
        sq.delete(); eq.delete();
        t_user = user; t_vpn = vpn; t_vma = vma; t_ubr = ubr; t_ebr = ebr;
        exp_adr = PA_W'((user ? int'(ubr) : int'(ebr)) * 512 + int'(vpn) / 2);
        word = rnd36();
        if (vpn[0]) word[17:0] = hw; else word[35:18] = hw;
        tag7 = {1'b1, user, vma};
`ifdef PT_PARITY_EN
        exp_pt  = {($countones(hw) % 2 == 0), hw};
        exp_tag = {($countones(tag7) % 2 == 0), tag7};
`else
        exp_pt  = hw;
        exp_tag = tag7;
`endif
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd36(), o_idle());
        pf_model = '0;
        ob = '0; ob.busy = 1'b1;
        push(rb(), 1'b0, 1'b0, 1'b0, 1'b1, rnd36(), ob);
        att = 0; fin = 0; aborted = 0;
        while (!fin) begin
            d  = (att == 0) ? d0 : d1;
            p  = (att == 0) ? p0 : p1;
            nw = (d > TIMEOUT) ? TIMEOUT : d;
            for (int k = 1; k <= nw; k++) begin
                bit ab, ak;
                w = ob; w.rd_req = 1'b1; w.adr = exp_adr;
                ab = (att == 0 && k == abort_at);
                ak = (k == d);
                push(rb(), ab, ak, ak ? p : rb(), 1'b1, ak ? word : rnd36(), w);
                if (ab) begin aborted = 1; break; end
            end
            if (aborted) begin
                push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rnd36(), o_idle());
                push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rnd36(), o_idle());
                push(1'b0, 1'b0, 1'b1, rb(), 1'b1, rnd36(), o_idle());
                push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd36(), o_idle());
                fin = 1;
            end else if (d > TIMEOUT) begin
                push_fail(5'o27); fin = 1;
            end else if (p) begin
                if (att < RETRIES) begin
                    push(rb(), 1'b0, 1'b0, 1'b0, 1'b1, rnd36(), ob);
                    att++;
                end else begin
                    push_fail(5'o25); fin = 1;
                end
            end else begin
                push(rb(), 1'b0, 1'b0, 1'b0, 1'b1, rnd36(), ob);
                if (!hw[17]) push_fail(5'o21);
                else begin
                    w = ob; w.pt_wr = 1'b1; w.pt_adr = vpn; w.pt_data = exp_pt;
                    push(rb(), 1'b0, 1'b0, 1'b0, 1'b1, rnd36(), w);
                    w = ob; w.dir_wr = 1'b1; w.done = 1'b1; w.tag = exp_tag;
                    push(rb(), 1'b0, 1'b0, 1'b0, 1'b1, rnd36(), w);
                end
                fin = 1;
            end
        end
        for (int g = 0; g < gap; g++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd36(), o_idle());
    endtask

    task automatic play();
        for (int i = 0; i < sq.size(); i++) begin
            @(posedge clk); #1;
            refill_req_h = sq[i].req; abort_h = sq[i].abort;
            bus.mem_rd_ack_h = sq[i].ack; bus.mem_par_err_h = sq[i].perr; bus.mem_data_h = sq[i].data;
            if (i == 0) begin
                vma_user_h = t_user; vma_18to26_h = t_vpn; vma_13to17_h = t_vma;
                ubr_h = t_ubr; ebr_h = t_ebr; start_cyc = cyc;
            end else if (sq[i].scr) begin
                vma_user_h = rb(); vma_18to26_h = 9'($urandom); vma_13to17_h = 5'($urandom);
            end
            exp_cur = eq[i]; exp_vld = 1'b1;
        end
    endtask

    task automatic stop_play();
        @(negedge clk); #1;
        exp_vld = 1'b0;
        refill_req_h = 1'b0; abort_h = 1'b0; bus.mem_rd_ack_h = 1'b0; bus.mem_par_err_h = 1'b0;
    endtask

    initial begin
        int s_rise, s_pulse, s_ptwr, s_done, s_hi;
        bus.mem_rd_ack_h = 1'b0; bus.mem_par_err_h = 1'b0; bus.mem_data_h = '0;
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", all_outs(), '0);
        @(negedge clk); crobar_l = 1'b1;

        // User refill, odd page, ack on the second WAIT cycle.
        build(1, 9'o007, 5'b10101, 13'o0123, 13'o7777, 18'o401234, 2, 1, 0, 0, 0, 1);
        play();
        check("user_adr", 128'(last_adr), 128'(22'o0123003));
`ifdef PT_PARITY_EN
        check("user_pt_data", 128'(last_pt), 128'(19'o1401234));
`else
        check("user_pt_data", 128'(last_pt), 128'(18'o401234));
`endif
        check("user_tag_hi", 128'(last_tag[6:5]), 128'(2'b11));
        check("user_latency", 128'(done_cyc - start_cyc), 128'(6));

        // Exec refill, even page, access bit clear.
        s_ptwr = pt_wr_cnt;
        build(0, 9'o010, 5'd3, 13'o1111, 13'o0456, 18'o0, 1, 1, 0, 0, 0, 1);
        play();
        check("noacc_code", 128'(pf_code_h), 128'(5'o21));
        check("noacc_no_ptwr", 128'(pt_wr_cnt - s_ptwr), 128'(0));

        // One parity error then a clean ack, back-to-back into two parity errors.
        s_rise = req_rise; s_done = done_cnt;
        build(1, 9'o123, 5'd9, 13'o0777, 13'o0001, 18'o612345, 1, 3, 1, 0, 0, 0);
        play();
        build(0, 9'o200, 5'd1, 13'o0002, 13'o1357, 18'o777777, 2, 1, 1, 1, 0, 1);
        play();
        check("retry_reqs", 128'(req_rise - s_rise), 128'(4));
        check("retry_done", 128'(done_cnt - s_done), 128'(1));
        check("parity_code", 128'(pf_code_h), 128'(5'o25));

        // No ack at all.
        s_hi = req_hi;
        build(1, 9'o044, 5'd7, 13'o0100, 13'o0200, 18'o400001, TIMEOUT + 10, 1, 0, 0, 0, 1);
        play();
        check("timeout_wait_cycles", 128'(req_hi - s_hi), 128'(TIMEOUT));
        check("timeout_code", 128'(pf_code_h), 128'(5'o27));
        check("timeout_req_low", 128'(bus.mem_rd_req_h), 128'(0));

        // Abort on the second WAIT cycle with a late ack; then abort colliding with an ack.
        s_pulse = pulses;
        build(1, 9'o321, 5'd2, 13'o0333, 13'o0444, 18'o400777, 20, 1, 0, 0, 2, 1);
        play();
        build(0, 9'o322, 5'd4, 13'o0335, 13'o0446, 18'o500000, 3, 1, 0, 0, 3, 1);
        play();
        check("abort_no_pulses", 128'(pulses - s_pulse), 128'(0));
        check("abort_idle", 128'({busy_h, pf_code_h}), 128'(0));

        // Reset in the middle of WAIT.
        stop_play();
        @(posedge clk); #1;
        refill_req_h = 1'b1; vma_user_h = 1'b0; vma_18to26_h = 9'o017; ebr_h = 13'o0042;
        @(posedge clk); #1 refill_req_h = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("req_before_reset", 128'(bus.mem_rd_req_h), 128'(1));
        #2 crobar_l = 1'b0;
        #1 check("reset_mid_wait", all_outs(), '0);
        @(negedge clk); #2 crobar_l = 1'b1;
        pf_model = '0;
        build(0, 9'o017, 5'd5, 13'o0041, 13'o0042, 18'o434343, 1, 1, 0, 0, 0, 1);
        play();

        for (int n = 0; n < 40; n++) begin
            logic [17:0] hw;
            int d0, ab;
            hw = 18'($urandom);
            hw[17] = ($urandom_range(0, 3) != 0);
            d0 = $urandom_range(1, 6);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, d0) : 0;
            build(rb(), 9'($urandom), 5'($urandom), 13'($urandom), 13'($urandom), hw, d0,
                  $urandom_range(1, 6), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ab, $urandom_range(0, 2));
            play();
        end
        stop_play();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
